// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results take priority, MDU results queue in a FIFO,
// and a pending scoreboard raises stall for operands still owed by the MDU. Optional WB_BYPASS_EN.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_hold,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  output logic        stall,
  output logic        RegWr,
  output logic [4:0]  Rw,
  output logic [31:0] busW
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pending_q, pending_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          alu_hold_q, alu_hold_d;
  logic          reg_wr_q, reg_wr_d;
  logic [4:0]    rw_q, rw_d;
  logic [31:0]   bus_w_q, bus_w_d;

  logic          full, empty, push_req, push, pop, bypass;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign mdu_ready = !arst && !full;
  assign push_req  = mdu_valid && mdu_ready;
  assign pop       = !alu_valid && !empty;
  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

`ifdef WB_BYPASS_EN
  assign bypass = !alu_valid && empty && push_req;
`else
  assign bypass = 1'b0;
`endif

  assign push = push_req && !bypass;

  always_comb begin
    reg_wr_d = 1'b0;
    rw_d     = rw_q;
    bus_w_d  = bus_w_q;
    if (alu_valid) begin
      reg_wr_d = (alu_rd != 5'd0);
      rw_d     = alu_rd;
      bus_w_d  = alu_data;
    end else if (pop) begin
      reg_wr_d = (head_rd != 5'd0);
      rw_d     = head_rd;
      bus_w_d  = head_data;
    end else if (bypass) begin
      reg_wr_d = (mdu_rd != 5'd0);
      rw_d     = mdu_rd;
      bus_w_d  = mdu_data;
    end
  end

  // Set is applied after clear so a same-cycle reissue of the popped register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (pop)    pending_d[head_rd] = 1'b0;
    if (bypass) pending_d[mdu_rd]  = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    starve_d   = '0;
    alu_hold_d = 1'b0;
    if (full && alu_valid) begin
      if (starve_q == SW'(STARVE_LIMIT - 1)) begin
        alu_hold_d = 1'b1;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      starve_q   <= '0;
      alu_hold_q <= 1'b0;
      reg_wr_q   <= 1'b0;
      rw_q       <= '0;
      bus_w_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      starve_q   <= starve_d;
      alu_hold_q <= alu_hold_d;
      reg_wr_q   <= reg_wr_d;
      rw_q       <= rw_d;
      bus_w_q    <= bus_w_d;
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= mdu_rd;
      fifo_data_q[wr_ptr_q] <= mdu_data;
    end
  end

  assign stall    = !arst && (pending_q[chk_rs] || pending_q[chk_rt]);
  assign alu_hold = alu_hold_q;
  assign RegWr    = reg_wr_q;
  assign Rw       = rw_q;
  assign busW     = bus_w_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts writes,
// readiness, stall and hold; a negedge monitor pops expected writes as RegWr appears.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef WB_BYPASS_EN
  localparam int MDU_LAT = 1;
`else
  localparam int MDU_LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst = 1'b1;
  logic        alu_valid = 1'b0, mdu_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]  alu_rd = '0, mdu_rd = '0, issue_rd = '0, chk_rs = '0, chk_rt = '0;
  logic [31:0] alu_data = '0, mdu_data = '0;
  logic        alu_hold, mdu_ready, stall, RegWr;
  logic [4:0]  Rw;
  logic [31:0] busW;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .arst(arst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_hold(alu_hold),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .stall(stall),
    .RegWr(RegWr), .Rw(Rw), .busW(busW)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t fifo_m[$];
  bit  pend_m[32];
  int  starve_m;
  bit  hold_m;
  bit  model_valid = 1'b0;
  bit  hold_seen = 1'b0;
  int  checks = 0, errors = 0;
  wr_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid && RegWr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_extra: got write Rw=%0d busW=%h expected no write", Rw, busW);
      end else begin
        mon_e = exp_q.pop_front();
        if (Rw !== mon_e.rd || busW !== mon_e.data) begin
          errors++;
          $display("FAIL wb_data: got Rw=%0d busW=%h expected Rw=%0d busW=%h",
                   Rw, busW, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  task automatic cycle(input bit rst, input bit a_v, input logic [4:0] a_rd, input logic [31:0] a_d,
                       input bit m_v, input logic [4:0] m_rd, input logic [31:0] m_d,
                       input bit i_v, input logic [4:0] i_rd,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input bit honor, output bit acc);
    bit  av, rdy, full, used;
    wr_t w;
    @(negedge clk);
    if (model_valid && alu_hold === 1'b1) hold_seen = 1'b1;
    av = a_v && !(honor && alu_hold === 1'b1);
    arst = rst; alu_valid = av; alu_rd = a_rd; alu_data = a_d;
    mdu_valid = m_v; mdu_rd = m_rd; mdu_data = m_d;
    issue_valid = i_v; issue_rd = i_rd; chk_rs = rs; chk_rt = rt;
    #1;
    rdy = !rst && (fifo_m.size() < DEPTH);
    if (model_valid) begin
      chk("mdu_ready", mdu_ready, rdy);
      chk("stall", stall, !rst && (pend_m[rs] || pend_m[rt]));
      chk("alu_hold", alu_hold, hold_m);
    end
    acc = m_v && rdy;
    if (rst) begin
      fifo_m.delete();
      foreach (pend_m[i]) pend_m[i] = 1'b0;
      starve_m = 0;
      hold_m = 1'b0;
      model_valid = 1'b1;
    end else begin
      full = (fifo_m.size() == DEPTH);
      used = 1'b0;
      if (av) begin
        w.rd = a_rd; w.data = a_d;
        if (a_rd != 0) exp_q.push_back(w);
      end else if (fifo_m.size() != 0) begin
        w = fifo_m.pop_front();
        if (w.rd != 0) exp_q.push_back(w);
        pend_m[w.rd] = 1'b0;
      end
`ifdef WB_BYPASS_EN
      else if (acc) begin
        w.rd = m_rd; w.data = m_d;
        if (m_rd != 0) exp_q.push_back(w);
        pend_m[m_rd] = 1'b0;
        used = 1'b1;
      end
`endif
      if (acc && !used) begin
        w.rd = m_rd; w.data = m_d;
        fifo_m.push_back(w);
      end
      if (i_v && i_rd != 0) pend_m[i_rd] = 1'b1;
      pend_m[0] = 1'b0;
      if (full && av) begin
        starve_m++;
        hold_m = (starve_m == LIMIT);
        if (hold_m) starve_m = 0;
      end else begin
        starve_m = 0;
        hold_m = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
    bit a;
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, rs, rt, 0, a);
  endtask

  initial begin
    bit a;
    int k;
    bit hv;
    logic [4:0]  hrd;
    logic [31:0] hd;
    int pa;

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    idle(0, 0);
    chk("rst_regwr", RegWr, 0);
    chk("rst_rw", Rw, 0);
    chk("rst_busw", busW, 0);

    cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, a);
    idle(0, 0);
    chk("alu_write", {RegWr, Rw, busW}, {1'b1, 5'd5, 32'hDEADBEEF});
    cycle(0, 1, 5'd0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, a);
    chk("idle_regwr", RegWr, 0);
    idle(0, 0);
    chk("rd0_regwr", RegWr, 0);

    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0, a);
    idle(5'd9, 5'd0);
    chk("stall_issue", stall, 1);
    cycle(0, 0, 0, 0, 1, 5'd9, 32'h1234, 0, 0, 5'd9, 0, 0, a);
    chk("mdu_accept", a, 1);
    for (int i = 0; i < MDU_LAT; i++) idle(5'd9, 5'd0);
    chk("mdu_latency", {RegWr, Rw, busW}, {1'b1, 5'd9, 32'h1234});
    chk("stall_clear", stall, 0);

    // Starvation: ALU busy every cycle until hold, MDU offering five results.
    k = 1;
    hold_seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle(0, 1, 5'(i % 4 + 1), 32'h5000 + 32'(i), k <= 5, 5'(10 + k), 32'hA000_0000 + 32'(k),
            0, 0, 0, 0, 1, a);
      if (a) k++;
    end
    chk("starve_hold_seen", hold_seen, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, k <= 5, 5'(10 + k), 32'hA000_0000 + 32'(k), 0, 0, 0, 0, 0, a);
      if (a) k++;
    end

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    cycle(0, 1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 0, 0, 0, 0, 0, a);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 0, a);
    idle(5'd7, 5'd0);
    chk("set_wins", stall, 1);

    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 0, 0, a);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd13, 0, 0, 0, a);
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 5'd1, 32'h1, 1, 5'(12 + i), 32'hC0 + 32'(i), 0, 0, 0, 0, 0, a);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd12, 5'd13, 0, a);
    idle(5'd12, 5'd13);
    chk("rst_mid_regwr", RegWr, 0);
    chk("rst_mid_ready", mdu_ready, 1);
    chk("rst_mid_stall", stall, 0);

    hv = 1'b0; hrd = '0; hd = '0; a = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      pa = (i / 250) % 3 == 0 ? 90 : ((i / 250) % 3 == 1 ? 50 : 15);
      if (!(hv && !a)) begin
        hv  = ($urandom_range(0, 99) < 45);
        hrd = 5'($urandom_range(0, 7));
        hd  = $urandom;
      end
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < pa, 5'($urandom_range(0, 7)), $urandom,
            hv, hrd, hd, $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, a);
    end
    for (int i = 0; i < 12; i++) idle(0, 0);
    chk("wb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback-side producer for the register-file write port (busW/RegWr plus a direct 5-bit write address).
- Merges single-cycle pipeline (ALU/load) results with out-of-order results from the multi-cycle multiply/divide unit (MDU).
- MDU results wait in a small FIFO.
- A 32-entry pending scoreboard drives a read-hazard stall for operand reads on busA/busB.

Parameters:
DEPTH, 4, MDU result FIFO entries; power of two, >= 2
STARVE_LIMIT, 8, consecutive cycles FIFO may sit full while ALU holds the port before alu_hold asserts

Ports:
clk  input  1  clock; all state updates on rising edge
arst  input  1  reset, synchronous, active-high
alu_valid  input  1  pipeline writeback request this cycle
alu_rd  input  5  pipeline destination register
alu_data  input  32  pipeline result
alu_hold  output  1  upstream must not present alu_valid next cycle
mdu_valid  input  1  MDU result offered
mdu_rd  input  5  MDU destination register
mdu_data  input  32  MDU result
mdu_ready  output  1  FIFO can accept; transfer when mdu_valid && mdu_ready
issue_valid  input  1  MDU operation issued this cycle
issue_rd  input  5  destination of issued MDU op
chk_rs  input  5  decode-stage source A
chk_rt  input  5  decode-stage source B
stall  output  1  chk_rs or chk_rt pending
RegWr  output  1  register-file write enable (registered)
Rw  output  5  register-file write address (registered)
busW  output  32  register-file write data (registered)

Behaviour:
- Reset (arst high at clock edge): RegWr=0, Rw=0, busW=0, FIFO count=0, pointers=0, scoreboard=0, starve counter=0, alu_hold=0.
- mdu_ready=0 and stall=0 while arst high. Otherwise mdu_ready = (count < DEPTH) and stall is combinational.
- Arbitration each cycle, fixed priority:
  1. alu_valid: next cycle RegWr=(alu_rd!=0), Rw=alu_rd, busW=alu_data.
  2. Else if FIFO not empty: pop head; next cycle RegWr=(head_rd!=0), Rw=head_rd, busW=head_data.
  3. Else: RegWr=0 next cycle. Rw and busW hold their previous values.
- Latency: ALU result appears 1 cycle after request. MDU result with no bypass appears >= 2 cycles after acceptance, because push and pop never happen on the same entry in one cycle.
- FIFO: push on mdu_valid&&mdu_ready. Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH. No push when full; mdu_valid with mdu_ready=0 is held by the MDU.
- rd=0 entries: accepted and popped normally; they consume a write slot with RegWr=0.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets pending[issue_rd].
  - A FIFO pop clears pending[head_rd].
  - Set and clear of the same index in the same cycle: set wins.
  - pending[0] is always 0.
  - stall = pending[chk_rs] | pending[chk_rt].
- Starvation:
  - Counter increments each cycle where FIFO is full and alu_valid=1.
  - Counter resets to 0 on any cycle where the FIFO is not full or alu_valid=0.
  - When counter reaches STARVE_LIMIT: alu_hold=1 (registered) for exactly one cycle, and the counter clears.
  - If alu_valid still arrives during hold, the ALU keeps priority; no error is flagged.
- Reset mid-operation: all queued MDU results and pending bits are discarded. No write is issued in the cycle following reset.

Optional Feature:
WB_BYPASS_EN
- Defined: when alu_valid=0, FIFO empty and mdu_valid&&mdu_ready, the MDU result goes directly to RegWr/Rw/busW next cycle without enqueueing (latency 1). Its pending bit clears in that same cycle.
- Undefined: every MDU result passes through the FIFO (minimum latency 2).

Test Plan:
- Reset then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle RegWr=1, Rw=5, busW=0xDEADBEEF; following idle cycle RegWr=0.
- alu_valid=1, alu_rd=0 -> RegWr stays 0 next cycle.
- issue rd=9, then chk_rs=9 -> stall=1. MDU delivers rd=9, data=0x1234 with ALU idle -> write appears 2 cycles after acceptance (1 with WB_BYPASS_EN), and stall drops in the pop cycle.
- ALU valid every cycle while MDU offers 5 results (DEPTH=4) -> mdu_ready=0 after 4 accepts. alu_hold pulses after 8 full+blocked cycles. Dropping alu_valid that cycle pops 0x...result1 first (FIFO order preserved).
- Same-cycle issue_rd=7 and pop of head rd=7 -> pending[7] remains 1.
- arst asserted with 3 queued entries and pending bits set -> next cycle count=0, mdu_ready=1, stall=0, RegWr=0.
